// File: rtl/pipe_hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
package pipe_hazard_fwd_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_num_t;

  localparam reg_num_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_EALU = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MMEM = 2'b11
  } fwd_sel_e;

  // Destination info carried by an instruction down the EXE/MEM shadow pipe.
  typedef struct packed {
    logic     wreg;
    logic     m2reg;
    reg_num_t rn;
  } dst_info_t;

endpackage

// File: rtl/pipe_hazard_fwd_ctrl_if.sv
// ID-stage decode fields in, forwarding selects / stall controls out.
interface pipe_hazard_fwd_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_fwd_ctrl_pkg::*;

  reg_num_t         drs;
  reg_num_t         drt;
  logic             duse_rs;
  logic             duse_rt;
  logic             dwreg;
  logic             dm2reg;
  reg_num_t         drn;
  logic             dflush;
  logic [1:0]       stall_a_depen;
  logic [1:0]       stall_b_depen;
  logic             wpcir;
  logic             dbubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dflush,
    input  stall_a_depen, stall_b_depen, wpcir, dbubble, stall_cnt
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dflush,
    output stall_a_depen, stall_b_depen, wpcir, dbubble, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_fwd_ctrl_fwd_sel.sv
// Per-operand forwarding select: nearest producer wins, r0 never forwards.
module pipe_hazard_fwd_ctrl_fwd_sel
  import pipe_hazard_fwd_ctrl_pkg::*;
(
  input  reg_num_t   i_src,
  input  logic       i_use,
  input  dst_info_t  i_e,
  input  dst_info_t  i_m,
  output logic [1:0] o_sel
);

  logic w_src_live;
  logic w_hit_e;
  logic w_hit_m;

  assign w_src_live = i_use && (i_src != REG_ZERO);
  // A load sitting in EXE has no data yet; the stall logic covers it instead.
  assign w_hit_e    = w_src_live && i_e.wreg && !i_e.m2reg && (i_e.rn == i_src);
  assign w_hit_m    = w_src_live && i_m.wreg && (i_m.rn == i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_e) begin
      o_sel = FWD_EALU;
    end else if (w_hit_m) begin
      o_sel = i_m.m2reg ? FWD_MMEM : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Shadow EXE/MEM destination tracking, load-use stall and stall-cycle counter.
module pipe_hazard_fwd_ctrl
  import pipe_hazard_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  pipe_hazard_fwd_ctrl_if.slave  bus
);

  dst_info_t        r_e;
  dst_info_t        r_m;
  logic [CNT_W-1:0] r_cnt;
  dst_info_t        w_d;
  logic             w_stall;
  logic             w_rs_dep;
  logic             w_rt_dep;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_d = '{wreg: bus.dwreg, m2reg: bus.dm2reg, rn: bus.drn};

  // Load-use: the loaded value only exists once the load reaches MEM.
  assign w_rs_dep = bus.duse_rs && (r_e.rn == bus.drs);
  assign w_rt_dep = bus.duse_rt && (r_e.rn == bus.drt);
  assign w_stall  = r_e.wreg && r_e.m2reg && (r_e.rn != REG_ZERO) && (w_rs_dep || w_rt_dep);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_e   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
    end else begin
      r_m <= r_e;
      r_e <= (w_stall || bus.dflush) ? '0 : w_d;
      if (w_stall) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  pipe_hazard_fwd_ctrl_fwd_sel u_sel_a (
    .i_src (bus.drs),
    .i_use (bus.duse_rs),
    .i_e   (r_e),
    .i_m   (r_m),
    .o_sel (bus.stall_a_depen)
  );

  pipe_hazard_fwd_ctrl_fwd_sel u_sel_b (
    .i_src (bus.drt),
    .i_use (bus.duse_rt),
    .i_e   (r_e),
    .i_m   (r_m),
    .o_sel (bus.stall_b_depen)
  );

  assign bus.wpcir     = ~w_stall;
  assign bus.dbubble   = w_stall | bus.dflush;
  assign bus.stall_cnt = r_cnt;

endmodule
